// File: rtl/adder_subtractor_32_pkg.sv
// Shared ALU constants for the add/sub slice.
// Pure declarations: no logic, no latency, no flow control.
package adder_subtractor_32_pkg;
    localparam int   ALU_WIDTH = 32;
    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;
endpackage

// File: rtl/adder_subtractor_32_if.sv
// Operand/result bundle between the ALU operand stage and the add/sub slice.
// No handshake: one operation per cycle, the consumer cannot stall.
interface adder_subtractor_32_if
    import adder_subtractor_32_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             M;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (output a, output b, output M, input sum, input c_out);
    modport slave  (input a, input b, input M, output sum, output c_out);
endinterface

// File: rtl/adder_subtractor_32_full_adder.sv
// One-bit full adder cell, chained to form the ripple carry path.
// Purely combinational; no backpressure.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/adder_subtractor_32.sv
// Registered two's-complement add/sub: M=0 gives a+b, M=1 gives a+~b+1.
// Latency 1 cycle, one op per cycle; no backpressure (no handshake).
module adder_subtractor_32
    import adder_subtractor_32_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_subtractor_32_if.slave bus
);
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_d;
    logic             c_out_q;

    // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
    assign sub_mode = (bus.M == MODE_SUB);
    assign b_eff    = bus.b ^ {WIDTH{sub_mode}};
    assign carry[0] = sub_mode;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a     (bus.a[i]),
            .b     (b_eff[i]),
            .c_in  (carry[i]),
            .s     (sum_d[i]),
            .c_out (carry[i+1])
        );
    end

    // In subtract mode this is the inverted borrow (1 when a >= b).
    assign c_out_d = carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_adder_subtractor_32.sv
module tb_adder_subtractor_32;
    import adder_subtractor_32_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    adder_subtractor_32_if #(.WIDTH(ALU_WIDTH)) bus ();

    adder_subtractor_32 #(.WIDTH(ALU_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned arithmetic straight from the mode definition.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic m);
        logic [32:0] r;
        if (m == MODE_ADD) r = {1'b0, a} + {1'b0, b};
        else               r = {(a >= b), a - b};
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic m);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.M = m;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        rst_n = 1'b0;
        bus.a = 32'd7; bus.b = 32'd8; bus.M = MODE_ADD;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.c_out, bus.sum} !== 33'd0) begin
            bad++;
            $display("FAIL reset_hold got c=%0b sum=%h want c=0 sum=0", bus.c_out, bus.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = ref_op(32'd7, 32'd8, MODE_ADD);
        total++;
        if ({bus.c_out, bus.sum} !== exp || bus.sum !== 32'd15) begin
            bad++;
            $display("FAIL reset_release got c=%0b sum=%0d want c=0 sum=15", bus.c_out, bus.sum);
        end
    endtask

    task automatic test_add_sweep();
        logic [32:0] exp;
        for (int a = 5; a <= 7; a++) begin
            for (int b = 6; b <= 8; b++) begin
                drive(32'(a), 32'(b), MODE_ADD);
                @(posedge clk); #1;
                exp = ref_op(32'(a), 32'(b), MODE_ADD);
                total++;
                if ({bus.c_out, bus.sum} !== exp || bus.sum !== 32'(a + b)) begin
                    bad++;
                    $display("FAIL add_%0d_%0d got c=%0b sum=%0d want c=%0b sum=%0d",
                             a, b, bus.c_out, bus.sum, exp[32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_sub_sweep();
        logic [32:0] exp;
        for (int a = 6; a <= 7; a++) begin
            for (int b = 0; b <= 4; b++) begin
                drive(32'(a), 32'(b), MODE_SUB);
                @(posedge clk); #1;
                exp = ref_op(32'(a), 32'(b), MODE_SUB);
                total++;
                if ({bus.c_out, bus.sum} !== exp || bus.c_out !== 1'b1) begin
                    bad++;
                    $display("FAIL sub_%0d_%0d got c=%0b sum=%0d want c=%0b sum=%0d",
                             a, b, bus.c_out, bus.sum, exp[32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vm [3];
        logic [32:0] want [3];
        va = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
        vb = '{32'h1, 32'h1,         32'h8000_0000};
        vm = '{MODE_SUB, MODE_ADD, MODE_SUB};
        want = '{{1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h0}, {1'b1, 32'h0}};
        for (int i = 0; i < 3; i++) begin
            drive(va[i], vb[i], vm[i]);
            @(posedge clk); #1;
            total++;
            if ({bus.c_out, bus.sum} !== want[i]) begin
                bad++;
                $display("FAIL boundary_%0d got c=%0b sum=%h want c=%0b sum=%h",
                         i, bus.c_out, bus.sum, want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic m;
        logic [32:0] want;
        for (int i = 0; i < 8; i++) begin
            m = i[0];
            drive(32'd10, 32'd3, m);
            @(posedge clk); #1;
            want = m ? {1'b1, 32'd7} : {1'b0, 32'd13};
            total++;
            if ({bus.c_out, bus.sum} !== want) begin
                bad++;
                $display("FAIL toggle_%0d got c=%0b sum=%0d want c=%0b sum=%0d",
                         i, bus.c_out, bus.sum, want[32], want[31:0]);
            end
        end
    endtask

    task automatic test_hold_between_edges();
        logic [32:0] want;
        drive(32'd100, 32'd1, MODE_SUB);
        @(posedge clk); #1;
        want = {1'b1, 32'd99};
        bus.a = 32'd5; bus.b = 32'd9; bus.M = MODE_ADD;
        #3;
        total++;
        if ({bus.c_out, bus.sum} !== want) begin
            bad++;
            $display("FAIL hold got c=%0b sum=%0d want c=1 sum=99", bus.c_out, bus.sum);
        end
        @(posedge clk); #1;
        want = ref_op(32'd5, 32'd9, MODE_ADD);
        total++;
        if ({bus.c_out, bus.sum} !== want) begin
            bad++;
            $display("FAIL hold_next got c=%0b sum=%0d want c=%0b sum=%0d",
                     bus.c_out, bus.sum, want[32], want[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        m;
        logic [32:0] exp_q [$];
        logic [32:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = (i % 7 == 0) ? a : $urandom;
            m = 1'($urandom_range(0, 1));
            drive(a, b, m);
            exp_q.push_back(ref_op(a, b, m));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            total++;
            if ({bus.c_out, bus.sum} !== exp) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h m=%0b got c=%0b sum=%h want c=%0b sum=%h",
                         i, a, b, m, bus.c_out, bus.sum, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(32'hFFFF_FFF0, 32'h20, MODE_ADD);
        @(posedge clk); #1;
        total++;
        if ({bus.c_out, bus.sum} !== ref_op(32'hFFFF_FFF0, 32'h20, MODE_ADD)) begin
            bad++;
            $display("FAIL async_pre got c=%0b sum=%h want c=1 sum=00000010", bus.c_out, bus.sum);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.c_out, bus.sum} !== 33'd0) begin
            bad++;
            $display("FAIL async_clear got c=%0b sum=%h want c=0 sum=0", bus.c_out, bus.sum);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.c_out, bus.sum} !== 33'd0) begin
            bad++;
            $display("FAIL async_held got c=%0b sum=%h want c=0 sum=0", bus.c_out, bus.sum);
        end
        drive(32'd20, 32'd25, MODE_SUB);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.c_out, bus.sum} !== ref_op(32'd20, 32'd25, MODE_SUB)) begin
            bad++;
            $display("FAIL async_release got c=%0b sum=%h want c=0 sum=fffffffb", bus.c_out, bus.sum);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.M = MODE_ADD;
        test_reset();
        test_add_sweep();
        test_sub_sweep();
        test_boundaries();
        test_back_to_back();
        test_hold_between_edges();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
